// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the elastic pipeline stage family:
//               depth limit, occupancy-width helper and the inter-stage
//               handshake bundle.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Deepest chain the elastic pipeline is built for
    localparam int PIPE_MAX_DEPTH = 8;

    // Bits needed to count 0..2*depth valid entries (two per stage)
    function automatic int clog2_occ(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    // Valid/ready pair carried between neighbouring stages
    typedef struct packed {
        logic valid;
        logic ready;
    } pipe_hs_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_slot
// Description : One elastic pipeline stage with a 2-entry skid buffer
//               (main + skid registers). Both i_in_ready and o_out_valid are
//               derived from registered flags only (plus flush/rst gating),
//               so no combinational ready path crosses the stage.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_flush             drop both entries at the next edge
//               i_in_valid/o_in_ready/i_in_data     upstream handshake
//               o_out_valid/i_out_ready/o_out_data  downstream handshake
//               o_fill              valid entries held (PIPE_STAGE_PERF_EN)
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [1:0]       o_fill
`endif
);

    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;

    logic             w_acc;
    logic             w_pop;

    // Gating with rst/flush makes the stage look empty and closed during
    // those cycles, so no handshake can complete while state is being wiped.
    assign o_in_ready  = !r_skid_valid && !i_flush && !rst;
    assign o_out_valid = r_main_valid && !i_flush && !rst;
    assign o_out_data  = rst ? RST_DATA : r_main;

    assign w_acc = i_in_valid && o_in_ready;
    assign w_pop = o_out_valid && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_main       <= RST_DATA;
            r_skid       <= RST_DATA;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            // Skid is never occupied while main is empty
            if (w_acc) begin
                r_main       <= i_in_data;
                r_main_valid <= 1'b1;
            end
        end else if (w_pop) begin
            if (r_skid_valid) begin
                // in_ready was low, so nothing new can arrive this cycle
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_main <= i_in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_acc) begin
            // Main is stuck: park the new word in the skid register
            r_skid       <= i_in_data;
            r_skid_valid <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    assign o_fill = 2'(r_main_valid) + 2'(r_skid_valid);
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Chain of DEPTH skid-buffered elastic stages carrying a
//               WIDTH-bit payload with valid/ready flow control, flush
//               (bubble insertion) and backpressure. Strict FIFO order,
//               DEPTH-cycle latency, capacity 2*DEPTH, 1 word/cycle.
// Ports       : clk, rst                       clock, sync active-high reset
//               flush                          kill all in-flight entries
//               in_valid/in_ready/in_data      upstream (stage 0)
//               out_valid/out_ready/out_data   downstream (stage DEPTH-1)
//               occupancy, stall_cycles        perf counters, present only
//                                              when PIPE_STAGE_PERF_EN is
//                                              defined
// Options     : `define PIPE_STAGE_PERF_EN to add the perf ports/logic
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 1,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [clog2_occ(DEPTH)-1:0]   occupancy,
    output logic [31:0]                   stall_cycles
`endif
);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_stage_elastic: DEPTH out of range 1..8");
    end

    // Index k is the boundary feeding stage k; index DEPTH is the block output
    pipe_hs_t         w_hs   [DEPTH+1];
    logic [WIDTH-1:0] w_data [DEPTH+1];
`ifdef PIPE_STAGE_PERF_EN
    logic [1:0]       w_fill [DEPTH];
`endif

    assign w_hs[0].valid     = in_valid;
    assign w_data[0]         = in_data;
    assign in_ready          = w_hs[0].ready;
    assign out_valid         = w_hs[DEPTH].valid;
    assign out_data          = w_data[DEPTH];
    assign w_hs[DEPTH].ready = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic w_slot_in_ready;
        logic w_slot_out_valid;

        pipe_stage_slot #(
            .WIDTH    (WIDTH),
            .RST_DATA (RST_DATA)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (flush),
            .i_in_valid  (w_hs[k].valid),
            .o_in_ready  (w_slot_in_ready),
            .i_in_data   (w_data[k]),
            .o_out_valid (w_slot_out_valid),
            .i_out_ready (w_hs[k+1].ready),
            .o_out_data  (w_data[k+1])
`ifdef PIPE_STAGE_PERF_EN
            ,
            .o_fill      (w_fill[k])
`endif
        );

        assign w_hs[k].ready   = w_slot_in_ready;
        assign w_hs[k+1].valid = w_slot_out_valid;
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam int c_occ_w = clog2_occ(DEPTH);

    logic [c_occ_w-1:0] w_occ;
    logic [31:0]        r_stall_cycles;

    // Sum of registered valid flags across all stages
    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + c_occ_w'(w_fill[k]);
        end
    end

    // Flush deliberately leaves this count alone; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign occupancy    = w_occ;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_elastic
// Description : Self-checking bench for pipe_stage_elastic (DEPTH=3,
//               RST_DATA=0xDEAD). A negedge monitor keeps a FIFO of accepted
//               words and compares every output transfer against it; it also
//               tracks expected occupancy and stall count when
//               PIPE_STAGE_PERF_EN is defined. Directed phases cover reset,
//               streaming latency, backpressure fill, flush and mid-stream
//               reset, followed by a random handshake run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int          c_width    = 32;
    localparam int          c_depth    = 3;
    localparam int          c_cap      = 2 * c_depth;
    localparam int          c_occ_w    = $clog2(2 * c_depth + 1);
    localparam logic [31:0] c_rst_data = 32'hDEAD;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [c_width-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [c_width-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [c_occ_w-1:0] occupancy;
    logic [31:0]        stall_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .WIDTH    (c_width),
        .DEPTH    (c_depth),
        .RST_DATA (c_rst_data)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
`endif
    );

    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_pops = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_stall = '0;
    bit          seen_aa = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / reference model, evaluated mid-cycle when all handshake
    // signals are stable; transfers seen here complete at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_stall = '0;
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            check("occupancy", 64'(occupancy), 64'(exp_q.size()));
            check("occ_bound", 64'(occupancy <= c_cap), 64'd1);
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
            if (out_valid && out_data == 32'hAA) seen_aa = 1'b1;
            if (flush) begin
                check("flush_in_ready", 64'(in_ready), 64'd0);
                check("flush_out_valid", 64'(out_valid), 64'd0);
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_data);
                if (out_valid && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, last, n_out, n_rdy, acc, rdy_k, pops0;
        logic [31:0] d;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'(c_rst_data));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // ---------------- stream 0x11..0x18 ----------------
        t0 = -1; t1 = -1; last = -1; n_out = 0; n_rdy = 0;
        for (int c = 0; c < 8 + c_depth + 4; c++) begin
            tick();
            in_valid = (c < 8);
            in_data  = 32'h11 + 32'(c);
            @(negedge clk);
            if (in_valid && in_ready) begin
                n_rdy++;
                if (t0 < 0) t0 = c;
            end
            if (out_valid) begin
                n_out++;
                if (t1 < 0) t1 = c;
                last = c;
            end
        end
        check("stream_latency", 64'(t1 - t0), 64'(c_depth));
        check("stream_accepts", 64'(n_rdy), 64'd8);
        check("stream_outputs", 64'(n_out), 64'd8);
        check("stream_no_gaps", 64'(last - t1 + 1), 64'd8);

        // ---------------- backpressure fill ----------------
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        d = 32'd1; acc = 0;
        for (int c = 0; c < 4 * c_depth + 4; c++) begin
            tick();
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                d = d + 1;
            end
        end
        check("bp_accepted", 64'(acc), 64'(c_cap));
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_valid", 64'(out_valid), 64'd1);
        check("bp_head_data", 64'(out_data), 64'd1);
        pops0 = n_pops;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_in_pop_cycle", 64'(in_ready), 64'd0);
        // Each stage frees its skid one cycle after its downstream does
        rdy_k = -1;
        for (int k = 1; k <= c_depth; k++) begin
            tick();
            @(negedge clk);
            if (in_ready && rdy_k < 0) rdy_k = k;
        end
        check("bp_ready_returns", 64'(rdy_k >= 1 && rdy_k <= c_depth), 64'd1);
        repeat (2 * c_depth + 4) tick();
        check("bp_drained_count", 64'(n_pops - pops0), 64'(c_cap));
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- flush mid-stream ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 32'h100 + 32'(i);
            @(negedge clk);
            check("flush_fill_accept", 64'(in_ready), 64'd1);
        end
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
        seen_aa = 1'b0; pops0 = n_pops;
        @(negedge clk);
        check("flush_cycle_in_ready", 64'(in_ready), 64'd0);
        check("flush_cycle_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("after_flush_in_ready", 64'(in_ready), 64'd1);
        check("after_flush_out_valid", 64'(out_valid), 64'd0);
        repeat (2 * c_depth + 4) tick();
        // Held flush with a word just entering
        in_valid = 1'b1; in_data = 32'h200;
        tick();
        flush = 1'b1; in_data = 32'hAA;
        repeat (3) tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("held_flush_out_valid", 64'(out_valid), 64'd0);
        check("held_flush_in_ready", 64'(in_ready), 64'd1);
        repeat (2 * c_depth + 4) tick();
        check("flush_no_outputs", 64'(n_pops - pops0), 64'd0);
        check("flush_no_aa", 64'(seen_aa), 64'd0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (c_depth + 2) tick();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_out_data", 64'(out_data), 64'(c_rst_data));
            check("midrst_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("after_midrst_in_ready", 64'(in_ready), 64'd1);
        check("after_midrst_out_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        check("after_midrst_occupancy", 64'(occupancy), 64'd0);
        check("after_midrst_stall", 64'(stall_cycles), 64'd0);
`endif

        // ---------------- random handshake ----------------
        for (int c = 0; c < 10000; c++) begin
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2 * c_depth + 4) tick();
        check("random_drain_empty", 64'(exp_q.size()), 64'd0);
        check("random_out_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
